// File: rtl/vga_pkg.sv
// Shared VGA framebuffer geometry and the fill-engine FSM encoding.
package vga_pkg;

  localparam int unsigned VGA_ADDR_WIDTH = 19;
  localparam int unsigned H_PHY_WIDTH    = 10;
  localparam int unsigned V_PHY_WIDTH    = 9;
  localparam int unsigned H_PHY_MAX      = 639;
  localparam int unsigned V_PHY_MAX      = 479;
  localparam int unsigned COLOR_ID_WIDTH = 8;

  typedef logic [1:0] fsm_state_t;

  localparam fsm_state_t ST_IDLE = 2'd0;
  localparam fsm_state_t ST_LOAD = 2'd1;
  localparam fsm_state_t ST_FILL = 2'd2;

endpackage

// File: rtl/rect_cmd_fifo.sv
// Synchronous command queue; full/empty derived from an occupancy count.
// DEPTH must be a power of two (pointers wrap naturally).
module rect_cmd_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == (PTR_W+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr_q];

  // Storage needs no reset; validity is tracked by the count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= wdata;
  end

  // Pointers and occupancy; push+pop together leaves the count unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/rect_fill_engine.sv
// Rectangle fill engine: queues rectangle commands and rasterises each one
// into framebuffer writes, one pixel per cycle, with incremental addressing.
// Optional macro RECT_FILL_CLIP_EN clips rectangles to the visible area.
module rect_fill_engine #(
  parameter int unsigned VGA_ADDR_WIDTH = vga_pkg::VGA_ADDR_WIDTH,
  parameter int unsigned H_PHY_WIDTH    = vga_pkg::H_PHY_WIDTH,
  parameter int unsigned V_PHY_WIDTH    = vga_pkg::V_PHY_WIDTH,
  parameter int unsigned H_PHY_MAX      = vga_pkg::H_PHY_MAX,
  parameter int unsigned V_PHY_MAX      = vga_pkg::V_PHY_MAX,
  parameter int unsigned COLOR_ID_WIDTH = vga_pkg::COLOR_ID_WIDTH,
  parameter int unsigned CMD_FIFO_DEPTH = 4
) (
  input  logic                      iclk,
  input  logic                      irst,
  input  logic                      icmd_valid,
  output logic                      ocmd_ready,
  input  logic [H_PHY_WIDTH-1:0]    itlx,
  input  logic [V_PHY_WIDTH-1:0]    itly,
  input  logic [H_PHY_WIDTH-1:0]    ibrx,
  input  logic [V_PHY_WIDTH-1:0]    ibry,
  input  logic [COLOR_ID_WIDTH-1:0] icolor,
  output logic                      owren,
  output logic [VGA_ADDR_WIDTH-1:0] oaddr,
  output logic [COLOR_ID_WIDTH-1:0] odata,
  output logic                      obusy,
  output logic                      odone
);

  import vga_pkg::*;

  localparam int unsigned CMD_W = 2 * H_PHY_WIDTH + 2 * V_PHY_WIDTH + COLOR_ID_WIDTH;
  localparam logic [VGA_ADDR_WIDTH-1:0] ROW_STRIDE = VGA_ADDR_WIDTH'(H_PHY_MAX + 1);
`ifdef RECT_FILL_CLIP_EN
  localparam logic [H_PHY_WIDTH-1:0] H_MAX = H_PHY_WIDTH'(H_PHY_MAX);
  localparam logic [V_PHY_WIDTH-1:0] V_MAX = V_PHY_WIDTH'(V_PHY_MAX);
`endif

  fsm_state_t state_q, state_d;

  logic                      push, pop, fifo_full, fifo_empty, queue_pending;
  logic [CMD_W-1:0]          wcmd, rcmd;
  logic [H_PHY_WIDTH-1:0]    h_tlx, h_brx, eff_brx;
  logic [V_PHY_WIDTH-1:0]    h_tly, h_bry, eff_bry;
  logic [COLOR_ID_WIDTH-1:0] h_color;
  logic                      degenerate;
  logic [VGA_ADDR_WIDTH-1:0] load_base;

  logic [H_PHY_WIDTH-1:0]    tlx_q, brx_q, x_q;
  logic [V_PHY_WIDTH-1:0]    bry_q, y_q;
  logic [VGA_ADDR_WIDTH-1:0] row_base_q, pix_addr_q, last_addr_q;
  logic [COLOR_ID_WIDTH-1:0] color_q, last_data_q;
  logic                      done_q;
  logic                      last_x, last_pixel;

  assign ocmd_ready = !fifo_full;
  assign push       = icmd_valid && ocmd_ready;
  assign pop        = (state_q == ST_LOAD);
  assign wcmd       = {itlx, itly, ibrx, ibry, icolor};
  assign {h_tlx, h_tly, h_brx, h_bry, h_color} = rcmd;

  rect_cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (CMD_FIFO_DEPTH)
  ) u_cmd_fifo (
    .clk   (iclk),
    .rst   (irst),
    .push  (push),
    .pop   (pop),
    .wdata (wcmd),
    .rdata (rcmd),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Counting an in-flight push lets an idle engine start the very next cycle.
  assign queue_pending = !fifo_empty || push;
  assign last_x        = (x_q == brx_q);
  assign last_pixel    = last_x && (y_q == bry_q);

  // Head-of-queue decode for LOAD: bounds, degeneracy and first-row base address.
  always_comb begin
    eff_brx    = h_brx;
    eff_bry    = h_bry;
`ifdef RECT_FILL_CLIP_EN
    if (h_brx > H_MAX) eff_brx = H_MAX;
    if (h_bry > V_MAX) eff_bry = V_MAX;
    degenerate = (h_tlx > H_MAX) || (h_tly > V_MAX) || (h_tlx > eff_brx) || (h_tly > eff_bry);
`else
    degenerate = (h_tlx > h_brx) || (h_tly > h_bry);
`endif
    load_base  = VGA_ADDR_WIDTH'(h_tly) * ROW_STRIDE + VGA_ADDR_WIDTH'(h_tlx);
  end

  // Next-state logic: IDLE -> LOAD -> FILL -> LOAD/IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (queue_pending) state_d = ST_LOAD;
      ST_LOAD: state_d = degenerate ? ST_IDLE : ST_FILL;
      ST_FILL: if (last_pixel) state_d = queue_pending ? ST_LOAD : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State register and raster datapath; reset abandons any fill in progress.
  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      state_q     <= ST_IDLE;
      tlx_q       <= '0;
      brx_q       <= '0;
      bry_q       <= '0;
      x_q         <= '0;
      y_q         <= '0;
      row_base_q  <= '0;
      pix_addr_q  <= '0;
      color_q     <= '0;
      last_addr_q <= '0;
      last_data_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      if (state_q == ST_LOAD) begin
        tlx_q      <= h_tlx;
        brx_q      <= eff_brx;
        bry_q      <= eff_bry;
        x_q        <= h_tlx;
        y_q        <= h_tly;
        row_base_q <= load_base;
        pix_addr_q <= load_base;
        color_q    <= h_color;
        done_q     <= degenerate;
      end else if (state_q == ST_FILL) begin
        last_addr_q <= pix_addr_q;
        last_data_q <= color_q;
        if (!last_x) begin
          x_q        <= x_q + 1'b1;
          pix_addr_q <= pix_addr_q + 1'b1;
        end else if (!last_pixel) begin
          x_q        <= tlx_q;
          y_q        <= y_q + 1'b1;
          row_base_q <= row_base_q + ROW_STRIDE;
          pix_addr_q <= row_base_q + ROW_STRIDE;
        end else begin
          done_q <= 1'b1;
        end
      end
    end
  end

  // Outputs hold the last written address/colour whenever no write is issued.
  assign owren = (state_q == ST_FILL);
  assign oaddr = owren ? pix_addr_q : last_addr_q;
  assign odata = owren ? color_q : last_data_q;
  assign obusy = (state_q != ST_IDLE) || !fifo_empty;
  assign odone = done_q;

endmodule

// File: tb/tb_rect_fill_engine.sv
// Self-checking bench for rect_fill_engine: randomised rectangles checked
// against a pixel-list reference model. Honours RECT_FILL_CLIP_EN.
module tb_rect_fill_engine;

  localparam int AW = 19, HW = 10, VW = 9, CW = 8, HMAX = 639, VMAX = 479;
`ifdef RECT_FILL_CLIP_EN
  localparam int NCLIP = 10;
`else
  localparam int NCLIP = 71;
`endif

  logic          iclk = 1'b0, irst = 1'b1, icmd_valid = 1'b0;
  logic [HW-1:0] itlx = '0, ibrx = '0;
  logic [VW-1:0] itly = '0, ibry = '0;
  logic [CW-1:0] icolor = '0;
  logic          ocmd_ready, owren, obusy, odone;
  logic [AW-1:0] oaddr;
  logic [CW-1:0] odata;

  rect_fill_engine dut (
    .iclk(iclk), .irst(irst), .icmd_valid(icmd_valid), .ocmd_ready(ocmd_ready),
    .itlx(itlx), .itly(itly), .ibrx(ibrx), .ibry(ibry), .icolor(icolor),
    .owren(owren), .oaddr(oaddr), .odata(odata), .obusy(obusy), .odone(odone)
  );

  always #5 iclk = ~iclk;

  int cyc = 0;
  always @(posedge iclk) cyc <= cyc + 1;

  int checks = 0, failures = 0;
  int wa[$], wd[$], wc[$], dc[$];  // observed writes and done pulses
  int ea[$], ed[$];                // expected writes

  // Observation log, sampled mid-cycle
  always @(negedge iclk) begin
    if (!irst) begin
      if (owren) begin
        wa.push_back(int'(oaddr));
        wd.push_back(int'(odata));
        wc.push_back(cyc);
      end
      if (odone) dc.push_back(cyc);
    end
  end

  // Reference: list every pixel the rectangle covers, in raster order
  function automatic void model_rect(int tlx, int tly, int brx, int bry, int color);
    int bx = brx, by = bry;
`ifdef RECT_FILL_CLIP_EN
    if (tlx > HMAX || tly > VMAX) return;
    if (bx > HMAX) bx = HMAX;
    if (by > VMAX) by = VMAX;
`endif
    for (int y = tly; y <= by; y++)
      for (int x = tlx; x <= bx; x++) begin
        ea.push_back((y * (HMAX + 1) + x) % (1 << AW));
        ed.push_back(color);
      end
  endfunction

  task automatic clear_obs();
    wa.delete(); wd.delete(); wc.delete(); dc.delete(); ea.delete(); ed.delete();
  endtask

  task automatic send_cmd(input int tlx, input int tly, input int brx, input int bry,
                          input int color, output int acc);
    acc = -1;
    @(posedge iclk); #1;
    itlx = HW'(tlx); itly = VW'(tly); ibrx = HW'(brx); ibry = VW'(bry); icolor = CW'(color);
    icmd_valid = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge iclk);
      if (ocmd_ready) begin acc = cyc; break; end
    end
    @(posedge iclk); #1;
    icmd_valid = 1'b0;
    if (acc < 0) begin
      checks++; failures++;
      $display("FAIL send_cmd: ocmd_ready never high (got 0, need 1)");
    end
  endtask

  task automatic wait_idle(input int budget);
    int quiet = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge iclk);
      if (!obusy && !odone) quiet++; else quiet = 0;
      if (quiet >= 4) return;
    end
    checks++; failures++;
    $display("FAIL wait_idle: obusy=%0b still after %0d cycles, need 0", obusy, budget);
  endtask

  task automatic test_reset();
    #2;
    checks++; if ({owren, odone, obusy} !== 3'b000) begin failures++;
      $display("FAIL reset_flags: owren/odone/obusy=%b need 000", {owren, odone, obusy}); end
    checks++; if (oaddr !== '0 || odata !== '0) begin failures++;
      $display("FAIL reset_outputs: oaddr=%0d odata=%0d need 0 0", oaddr, odata); end
    repeat (3) @(posedge iclk);
    #2 irst = 1'b0;
    @(posedge iclk); #1;
    checks++; if (ocmd_ready !== 1'b1) begin failures++;
      $display("FAIL reset_ready: ocmd_ready=%b need 1", ocmd_ready); end
  endtask

  task automatic test_small_rect();
    int acc;
    clear_obs();
    model_rect(0, 0, 1, 1, 'h0f);
    send_cmd(0, 0, 1, 1, 'h0f, acc);
    wait_idle(100);
    checks++; if (wa.size() != 4) begin failures++;
      $display("FAIL small_count: writes=%0d need 4", wa.size()); end
    for (int i = 0; i < wa.size() && i < ea.size(); i++) begin
      checks++; if (wa[i] != ea[i] || wd[i] != ed[i]) begin failures++;
        $display("FAIL small_pix%0d: addr=%0d data=%0h need %0d %0h", i, wa[i], wd[i], ea[i], ed[i]); end
    end
    if (wa.size() == 4) begin
      checks++; if (wc[0] != acc + 2 || wc[3] != acc + 5) begin failures++;
        $display("FAIL small_timing: first=%0d last=%0d need %0d %0d", wc[0], wc[3], acc + 2, acc + 5); end
    end
    checks++; if (dc.size() != 1 || (dc.size() == 1 && dc[0] != acc + 6)) begin failures++;
      $display("FAIL small_done: pulses=%0d need 1 at cycle %0d", dc.size(), acc + 6); end
  endtask

  task automatic test_corner();
    int acc;
    clear_obs();
    model_rect(638, 478, 639, 479, 'hff);
    send_cmd(638, 478, 639, 479, 'hff, acc);
    wait_idle(100);
    checks++; if (wa.size() != ea.size()) begin failures++;
      $display("FAIL corner_count: writes=%0d need %0d", wa.size(), ea.size()); end
    for (int i = 0; i < wa.size() && i < ea.size(); i++) begin
      checks++; if (wa[i] != ea[i] || wd[i] != ed[i]) begin failures++;
        $display("FAIL corner_pix%0d: addr=%0d data=%0h need %0d %0h", i, wa[i], wd[i], ea[i], ed[i]); end
    end
    checks++; if (dc.size() != 1) begin failures++;
      $display("FAIL corner_done: pulses=%0d need 1", dc.size()); end
  endtask

  task automatic test_back_to_back();
    int tx[5], ty[5], acc0 = -1, k = 0;
    bit took;
    clear_obs();
    for (int i = 0; i < 5; i++) begin
      tx[i] = $urandom_range(0, HMAX - 9);
      ty[i] = $urandom_range(0, VMAX - 9);
      model_rect(tx[i], ty[i], tx[i] + 9, ty[i] + 9, 'h10 + i);
    end
    @(posedge iclk); #1;
    itlx = HW'(tx[0]); itly = VW'(ty[0]); ibrx = HW'(tx[0] + 9); ibry = VW'(ty[0] + 9);
    icolor = CW'('h10); icmd_valid = 1'b1;
    for (int it = 0; it < 300 && k < 5; it++) begin
      @(negedge iclk);
      took = ocmd_ready;
      if (took && k == 0) acc0 = cyc;
      @(posedge iclk); #1;
      if (took) begin
        k++;
        if (k < 5) begin
          itlx = HW'(tx[k]); itly = VW'(ty[k]); ibrx = HW'(tx[k] + 9); ibry = VW'(ty[k] + 9);
          icolor = CW'('h10 + k);
        end
      end
    end
    icmd_valid = 1'b0;
    @(negedge iclk);
    checks++; if (ocmd_ready !== 1'b0) begin failures++;
      $display("FAIL b2b_full: ocmd_ready=%b need 0 with four queued", ocmd_ready); end
    checks++; if (k != 5) begin failures++;
      $display("FAIL b2b_accept: accepted=%0d need 5", k); end
    wait_idle(1000);
    checks++; if (wa.size() != 500) begin failures++;
      $display("FAIL b2b_count: writes=%0d need 500", wa.size()); end
    for (int i = 0; i < wa.size() && i < ea.size(); i++) begin
      checks++; if (wa[i] != ea[i] || wd[i] != ed[i]) begin failures++;
        $display("FAIL b2b_pix%0d: addr=%0d data=%0h need %0d %0h", i, wa[i], wd[i], ea[i], ed[i]); end
      if (i > 0) begin
        checks++; if (wc[i] - wc[i-1] != ((i % 100 == 0) ? 2 : 1)) begin failures++;
          $display("FAIL b2b_gap%0d: gap=%0d need %0d", i, wc[i] - wc[i-1], (i % 100 == 0) ? 2 : 1); end
      end
    end
    if (wa.size() > 0) begin
      checks++; if (wc[0] != acc0 + 2) begin failures++;
        $display("FAIL b2b_latency: first=%0d need %0d", wc[0], acc0 + 2); end
    end
    checks++; if (dc.size() != 5) begin failures++;
      $display("FAIL b2b_done: pulses=%0d need 5", dc.size()); end
  endtask

  task automatic test_degenerate();
    int acc;
    clear_obs();
    send_cmd(5, 2, 4, 3, $urandom_range(0, 255), acc);
    wait_idle(100);
    checks++; if (wa.size() != 0) begin failures++;
      $display("FAIL degen_writes: writes=%0d need 0", wa.size()); end
    checks++; if (dc.size() != 1 || (dc.size() == 1 && dc[0] != acc + 2)) begin failures++;
      $display("FAIL degen_done: pulses=%0d need 1 at cycle %0d", dc.size(), acc + 2); end
    checks++; if (obusy !== 1'b0) begin failures++;
      $display("FAIL degen_busy: obusy=%b need 0", obusy); end
  endtask

  task automatic test_clip_row();
    int acc, col;
    col = $urandom_range(0, 255);
    clear_obs();
    model_rect(630, 0, 700, 0, col);
    send_cmd(630, 0, 700, 0, col, acc);
    wait_idle(300);
    checks++; if (wa.size() != NCLIP) begin failures++;
      $display("FAIL clip_count: writes=%0d need %0d", wa.size(), NCLIP); end
    for (int i = 0; i < wa.size() && i < ea.size(); i++) begin
      checks++; if (wa[i] != ea[i] || wd[i] != ed[i]) begin failures++;
        $display("FAIL clip_pix%0d: addr=%0d data=%0h need %0d %0h", i, wa[i], wd[i], ea[i], ed[i]); end
    end
    checks++; if (dc.size() != 1) begin failures++;
      $display("FAIL clip_done: pulses=%0d need 1", dc.size()); end
  endtask

  task automatic test_random();
    int acc, tlx, tly, brx, bry;
    clear_obs();
    for (int n = 0; n < 12; n++) begin
      tlx = $urandom_range(0, HMAX);
      tly = $urandom_range(0, VMAX);
      brx = tlx + $urandom_range(0, 5);
      bry = tly + $urandom_range(0, 4);
      if ($urandom_range(0, 5) == 0 && tlx > 0) brx = tlx - 1;
      model_rect(tlx, tly, brx, bry, n * 17 + 3);
      send_cmd(tlx, tly, brx, bry, n * 17 + 3, acc);
    end
    wait_idle(2000);
    checks++; if (wa.size() != ea.size()) begin failures++;
      $display("FAIL rand_count: writes=%0d need %0d", wa.size(), ea.size()); end
    for (int i = 0; i < wa.size() && i < ea.size(); i++) begin
      checks++; if (wa[i] != ea[i] || wd[i] != ed[i]) begin failures++;
        $display("FAIL rand_pix%0d: addr=%0d data=%0h need %0d %0h", i, wa[i], wd[i], ea[i], ed[i]); end
    end
    checks++; if (dc.size() != 12) begin failures++;
      $display("FAIL rand_done: pulses=%0d need 12", dc.size()); end
  endtask

  task automatic test_reset_mid_fill();
    int acc;
    clear_obs();
    send_cmd(0, 0, 9, 9, 'h5a, acc);
    for (int i = 0; i < 200; i++) begin
      @(negedge iclk); #1;
      if (wa.size() >= 3) break;
    end
    checks++; if (wa.size() != 3) begin failures++;
      $display("FAIL midrst_start: writes=%0d need 3 before reset", wa.size()); end
    irst = 1'b1;
    #1;
    checks++; if ({owren, odone, obusy} !== 3'b000) begin failures++;
      $display("FAIL midrst_flags: owren/odone/obusy=%b need 000", {owren, odone, obusy}); end
    checks++; if (oaddr !== '0 || odata !== '0 || ocmd_ready !== 1'b1) begin failures++;
      $display("FAIL midrst_outputs: oaddr=%0d odata=%0d ready=%b need 0 0 1", oaddr, odata, ocmd_ready); end
    repeat (2) @(posedge iclk);
    #3 irst = 1'b0;
    repeat (30) @(negedge iclk);
    checks++; if (wa.size() != 3 || dc.size() != 0 || obusy !== 1'b0) begin failures++;
      $display("FAIL midrst_after: writes=%0d dones=%0d obusy=%b need 3 0 0", wa.size(), dc.size(), obusy); end
  endtask

  initial begin
    test_reset();
    test_small_rect();
    test_corner();
    test_back_to_back();
    test_degenerate();
    test_clip_row();
    test_random();
    test_reset_mid_fill();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rect_fill_engine.md
RECT_FILL_ENGINE -- requirements
Module: rect_fill_engine

Interface
REQ-001 Parameter VGA_ADDR_WIDTH, 19, framebuffer address width.
REQ-002 Parameter H_PHY_WIDTH, 10, physical x width.
REQ-003 Parameter V_PHY_WIDTH, 9, physical y width.
REQ-004 Parameter H_PHY_MAX, 639, last visible column.
REQ-005 Parameter V_PHY_MAX, 479, last visible row.
REQ-006 Parameter COLOR_ID_WIDTH, 8, colour index width.
REQ-007 Parameter CMD_FIFO_DEPTH, 4, command queue entries (power of two).
REQ-008 iclk  input  1  single clock; all logic on rising edge.
REQ-009 irst  input  1  reset, asynchronous, active-high.
REQ-010 icmd_valid  input  1  rectangle command present.
REQ-011 ocmd_ready  output  1  queue can accept a command.
REQ-012 itlx/ibrx  input  H_PHY_WIDTH  top-left / bottom-right x, inclusive.
REQ-013 itly/ibry  input  V_PHY_WIDTH  top-left / bottom-right y, inclusive.
REQ-014 icolor  input  COLOR_ID_WIDTH  fill colour index.
REQ-015 owren  output  1  framebuffer write strobe.
REQ-016 oaddr  output  VGA_ADDR_WIDTH  write address = y*(H_PHY_MAX+1)+x.
REQ-017 odata  output  COLOR_ID_WIDTH  write colour.
REQ-018 obusy  output  1  queue non-empty or fill in progress.
REQ-019 odone  output  1  one-cycle pulse per retired command.

Function
REQ-020 Command accepted on cycle where icmd_valid && ocmd_ready; ocmd_ready = queue not full, combinational from count; push while full is ignored.
REQ-021 Simultaneous push and pop: count unchanged, both take effect.
REQ-022 FSM states IDLE, LOAD, FILL; IDLE->LOAD when queue non-empty; LOAD pops head, latches coordinates/colour, computes row base; LOAD->FILL; FILL->LOAD if queue non-empty at last write, else IDLE.
REQ-023 Latency: command accepted at cycle N into empty idle engine -> first owren at N+2.
REQ-024 FILL issues exactly one write per cycle, raster order: x tlx..brx, then y+1, x back to tlx; no gaps within a command.
REQ-025 Address generated incrementally (+1 per pixel, row base +H_PHY_MAX+1 per row); no multiplier in FILL path.
REQ-026 odone asserts in the cycle after the last write of a command.
REQ-027 Degenerate command (tlx>brx or tly>bry): zero writes, odone pulses in the cycle after LOAD.
REQ-028 owren low in IDLE and LOAD; oaddr/odata hold last value when owren low.

Reset
REQ-029 irst asserted: immediately owren=0, odone=0, obusy=0, oaddr=0, odata=0, queue emptied, FSM=IDLE; in-progress fill abandoned, no further writes.
REQ-030 ocmd_ready=1 from first clock edge after irst deasserts.

Configuration
REQ-031 Macro RECT_FILL_CLIP_EN defined: in LOAD, brx clamped to H_PHY_MAX, bry clamped to V_PHY_MAX; tlx>H_PHY_MAX or tly>V_PHY_MAX treated as degenerate (REQ-027).
REQ-032 Macro undefined: coordinates used unmodified; out-of-range rectangles write computed addresses truncated to VGA_ADDR_WIDTH; caller is responsible for bounds.

Structure
REQ-033 Shared package vga_pkg holds VGA_ADDR_WIDTH, H/V_PHY_WIDTH, H/V_PHY_MAX, COLOR_ID_WIDTH and the FSM state typedef.
REQ-034 Command queue is one sub-module, rect_cmd_fifo (synchronous FIFO, count-based full/empty, same clock/reset).

Verification
REQ-035 Rect (0,0)-(1,1) colour 0x0f -> writes addr 0,1,640,641 data 0x0f, one per cycle, first at N+2, odone next cycle.
REQ-036 Rect (638,478)-(639,479) colour 0xff -> addr 306558,306559,307198,307199, odone once.
REQ-037 Five back-to-back commands (each 10x10) with icmd_valid held -> ocmd_ready low after 4th accepted while filling; all 5 commands produce 100 writes each, 5 odone pulses, no idle cycle between commands.
REQ-038 Degenerate tlx=5 brx=4 -> zero owren, single odone pulse, obusy returns low.
REQ-039 With RECT_FILL_CLIP_EN, rect (630,0)-(700,0) -> 10 writes addr 630..639; without macro -> 71 writes addr 630..700.
REQ-040 irst asserted mid-fill after 3 writes of (0,0)-(9,9) -> owren low same cycle, no odone, queue empty, obusy=0.
